// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the floating-point ALU units
// (this divider and the fused multiplier use the same saturation codes).
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int BIAS  = 63;
  localparam int CNT_W = 5;

  localparam logic [EXP_W-1:0] EXP_INF = 8'h7F;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp_div_step
  import fp_pkg::*;
(
  input  logic [MAN_W:0]   rem_i,
  input  logic [MAN_W-1:0] div_i,
  output logic [MAN_W:0]   rem_o,
  output logic             q_bit_o
);

  logic [MAN_W:0] diff_s;

  // The remainder stays below the divisor after each step, so the shift never loses a set bit.
  always_comb begin
    diff_s = rem_i - {1'b0, div_i};
    if (rem_i >= {1'b0, div_i}) begin
      q_bit_o = 1'b1;
      rem_o   = diff_s << 1;
    end else begin
      q_bit_o = 1'b0;
      rem_o   = rem_i << 1;
    end
  end

endmodule

// File: rtl/fp_seq_divider.sv
// Iterative floating-point divider Q = A / B, one quotient bit per cycle,
// with valid/ready handshakes on both the operand and the result side.
module fp_seq_divider
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] expA,
  input  logic [EXP_W-1:0] expB,
  input  logic [MAN_W-1:0] manA,
  input  logic [MAN_W-1:0] manB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] expAns,
  output logic [MAN_W-1:0] manAns,
  output logic             dz,
  output logic             ovf
);

  localparam logic signed [EXP_W+1:0] E_HI = (EXP_W+2)'(EXP_MAX);
  localparam logic signed [EXP_W+1:0] E_LO = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] E_BIAS = (EXP_W+2)'(BIAS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAN_W:0]     rem_q, rem_d;
  logic [MAN_W:0]     quo_q, quo_d;
  logic [EXP_W-1:0]   exp_a_q, exp_a_d;
  logic [EXP_W-1:0]   exp_b_q, exp_b_d;
  logic [MAN_W-1:0]   man_b_q, man_b_d;
  logic               dz_pend_q, dz_pend_d;
  logic               zero_pend_q, zero_pend_d;
  logic [EXP_W-1:0]   exp_ans_q, exp_ans_d;
  logic [MAN_W-1:0]   man_ans_q, man_ans_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;

  logic [MAN_W:0]          step_rem_s;
  logic                    step_q_bit_s;
  logic signed [EXP_W+1:0] exp_e_s;
  logic [MAN_W-1:0]        norm_man_s;

  fp_div_step u_step (
    .rem_i   (rem_q),
    .div_i   (man_b_q),
    .rem_o   (step_rem_s),
    .q_bit_o (step_q_bit_s)
  );

  // Unbiased exponent difference rebiased; one less when the quotient is below 1.0.
  always_comb begin
    exp_e_s = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q}) + E_BIAS
              - $signed({{(EXP_W+1){1'b0}}, ~quo_q[MAN_W]});
    if (quo_q[MAN_W]) begin
      norm_man_s = quo_q[MAN_W:1];
    end else begin
      norm_man_s = quo_q[MAN_W-1:0];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    man_b_d     = man_b_q;
    dz_pend_d   = dz_pend_q;
    zero_pend_d = zero_pend_q;
    exp_ans_d   = exp_ans_q;
    man_ans_d   = man_ans_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_a_d     = expA;
          exp_b_d     = expB;
          man_b_d     = manB;
          rem_d       = {1'b0, manA};
          quo_d       = '0;
          cnt_d       = '0;
          dz_pend_d   = (manB == '0);
          zero_pend_d = (manA == '0);
          // Zero operands skip the iteration and resolve directly in NORM.
          if ((manB == '0) || (manA == '0)) begin
            state_d = NORM;
          end else begin
            state_d = DIVIDE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        rem_d = step_rem_s;
        quo_d = {quo_q[MAN_W-1:0], step_q_bit_s};
        if (cnt_q == CNT_W'(MAN_W)) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      NORM: begin
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
        state_d = DONE;
        if (dz_pend_q) begin
          exp_ans_d = EXP_INF;
          man_ans_d = '0;
          dz_d      = 1'b1;
        end else if (zero_pend_q) begin
          exp_ans_d = '0;
          man_ans_d = '0;
        end else if (exp_e_s > E_HI) begin
          exp_ans_d = EXP_INF;
          man_ans_d = '0;
          ovf_d     = 1'b1;
        end else if (exp_e_s < E_LO) begin
          exp_ans_d = '0;
          man_ans_d = '0;
        end else begin
          exp_ans_d = exp_e_s[EXP_W-1:0];
          man_ans_d = norm_man_s;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      man_b_q     <= '0;
      dz_pend_q   <= 1'b0;
      zero_pend_q <= 1'b0;
      exp_ans_q   <= '0;
      man_ans_q   <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      man_b_q     <= man_b_d;
      dz_pend_q   <= dz_pend_d;
      zero_pend_q <= zero_pend_d;
      exp_ans_q   <= exp_ans_d;
      man_ans_q   <= man_ans_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign expAns    = exp_ans_q;
  assign manAns    = man_ans_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_seq_divider.sv
// Scoreboard bench for fp_seq_divider: directed vectors with hand-computed results.
module tb_fp_seq_divider;
  import fp_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [EXP_W-1:0] expA = '0, expB = '0;
  logic [MAN_W-1:0] manA = '0, manB = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [EXP_W-1:0] expAns;
  logic [MAN_W-1:0] manAns;
  logic             dz, ovf;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic        dz;
    logic        ovf;
    int          lat;
    int          acc_cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  logic prev_valid = 1'b0;

  fp_seq_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .expA(expA), .expB(expB), .manA(manA), .manB(manB),
    .out_valid(out_valid), .out_ready(out_ready),
    .expAns(expAns), .manAns(manAns), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compare each handshaked result against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (out_valid && !prev_valid) first_cyc = cyc;
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk({x.nm, "_exp"}, {24'd0, expAns}, {24'd0, x.e});
        chk({x.nm, "_man"}, {8'd0, manAns}, {8'd0, x.m});
        chk({x.nm, "_dz"}, {31'd0, dz}, {31'd0, x.dz});
        chk({x.nm, "_ovf"}, {31'd0, ovf}, {31'd0, x.ovf});
        chk({x.nm, "_lat"}, first_cyc - x.acc_cyc, x.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input string nm, input logic [7:0] ea, input logic [23:0] ma,
                      input logic [7:0] eb, input logic [23:0] mb,
                      input logic [7:0] re, input logic [23:0] rm,
                      input logic rdz, input logic rovf, input int lat);
    exp_t x;
    int   n;
    expA = ea; manA = ma; expB = eb; manB = mb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x.e = re; x.m = rm; x.dz = rdz; x.ovf = rovf; x.lat = lat;
    x.acc_cyc = cyc; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_done_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_exp", {24'd0, expAns}, 32'd0);
    chk("rst_man", {8'd0, manAns}, 32'd0);
    chk("rst_flags", {30'd0, dz, ovf}, 32'd0);

    send("one_div_one", 8'h3F, 24'h800000, 8'h3F, 24'h800000, 8'h3F, 24'h800000, 1'b0, 1'b0, 26);
    drain("one_div_one");
    send("two_div_1p5", 8'h40, 24'h800000, 8'h3F, 24'hC00000, 8'h3F, 24'hAAAAAA, 1'b0, 1'b0, 26);
    drain("two_div_1p5");
    send("1p5_div_one", 8'h3F, 24'hC00000, 8'h3F, 24'h800000, 8'h3F, 24'hC00000, 1'b0, 1'b0, 26);
    drain("1p5_div_one");
    send("div_zero", 8'h50, 24'h900000, 8'h3F, 24'h000000, 8'h7F, 24'h000000, 1'b1, 1'b0, 1);
    drain("div_zero");
    send("zero_num", 8'h3F, 24'h000000, 8'h3F, 24'h800000, 8'h00, 24'h000000, 1'b0, 1'b0, 1);
    drain("zero_num");
    send("zero_zero", 8'h3F, 24'h000000, 8'h3F, 24'h000000, 8'h7F, 24'h000000, 1'b1, 1'b0, 1);
    drain("zero_zero");
    send("overflow", 8'h7E, 24'h800000, 8'h00, 24'h800000, 8'h7F, 24'h000000, 1'b0, 1'b1, 26);
    drain("overflow");
    send("underflow", 8'h00, 24'h800000, 8'h7E, 24'h800000, 8'h00, 24'h000000, 1'b0, 1'b0, 26);
    drain("underflow");

    // Back-pressure: result held, new operands ignored while DONE is stalled.
    out_ready = 1'b0;
    send("hold", 8'h40, 24'h800000, 8'h3F, 24'hC00000, 8'h3F, 24'hAAAAAA, 1'b0, 1'b0, 26);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", {31'd0, out_valid}, 32'd1);
    expA = 8'h10; manA = 24'hFFFFFF; expB = 8'h20; manB = 24'h000000;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_exp", {24'd0, expAns}, 32'h3F);
      chk("hold_man", {8'd0, manAns}, 32'hAAAAAA);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_drained", sb.size(), 32'd0);
    sb.delete();

    // Reset in the middle of an iteration.
    send("aborted", 8'h3F, 24'h800000, 8'h3F, 24'h800000, 8'h3F, 24'h800000, 1'b0, 1'b0, 26);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_exp", {24'd0, expAns}, 32'd0);
    chk("abort_man", {8'd0, manAns}, 32'd0);
    chk("abort_flags", {30'd0, dz, ovf}, 32'd0);
    send("after_abort", 8'h40, 24'h800000, 8'h3F, 24'hC00000, 8'h3F, 24'hAAAAAA, 1'b0, 1'b0, 26);
    drain("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
